// File: rtl/vic_pkg.sv
// Shared types and default constants for the vectored interrupt controller.
// No logic; the FSM state encoding and default vector layout live here.
// Imported by the controller top and its per-channel cell.
package vic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2,
        RETURN   = 2'd3
    } vic_state_e;

    // Channel 0 vector and spacing between consecutive channel vectors.
    localparam logic [31:0] VIC_VEC_BASE   = 32'h0000_0180;
    localparam int          VIC_VEC_STRIDE = 8;
    localparam int          VIC_MAX_IRQ    = 16;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel: 2-flop synchroniser plus pending cell (edge or level).
// Latency: request sampled at edges 1,2; pending visible after edge 3.
// No backpressure; a set coinciding with a clear wins so no event is lost.
module irq_sync_edge
    import vic_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async_i,
    input  logic clr_i,
    output logic pending_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic set_w;

    // Edge channels latch a synchronised rising edge; level channels track the synchronised line.
    assign set_w = EDGE ? (sync2_q & ~prev_q) : sync2_q;

    // Next pending value: set has priority over clear; level channels ignore clear.
    always_comb begin
        pend_d = pend_q;
        if (EDGE) begin
            if (set_w) begin
                pend_d = 1'b1;
            end else if (clr_i) begin
                pend_d = 1'b0;
            end
        end else begin
            pend_d = sync2_q;
        end
    end

    // Synchroniser, edge-detect history and pending register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= irq_async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/vectored_irq_ctrl.sv
// Vectored interrupt controller: pending/mask/priority, PC redirect to vector, EPC save, eret return.
// Latency: irq_in rising -> take_int in the cycle after the 4th clock edge when idle and unmasked.
// No backpressure; requests accumulate in pending while a channel is in service (no nesting).
module vectored_irq_ctrl
    import vic_pkg::*;
#(
    parameter int                   NUM_IRQ    = 4,
    parameter int                   AW         = 32,
    parameter logic [AW-1:0]        VEC_BASE   = AW'(VIC_VEC_BASE),
    parameter int                   VEC_STRIDE = VIC_VEC_STRIDE,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = {NUM_IRQ{1'b1}},
    parameter logic [NUM_IRQ-1:0]   MASK_RST   = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               global_en,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wd,
    input  logic [AW-1:0]      pc_next,
    input  logic               eret,
    output logic               take_int,
    output logic [AW-1:0]      vec_addr,
    output logic               ret_take,
    output logic [AW-1:0]      epc_out,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic               in_service,
    output logic [3:0]         cur_id,
    output logic [NUM_IRQ-1:0] mask_q,
    output logic [NUM_IRQ-1:0] pending_q
);

    localparam logic [AW-1:0] STRIDE_W = AW'(VEC_STRIDE);

    vic_state_e          state_q;
    vic_state_e          state_d;
    logic [3:0]          cur_id_q;
    logic [3:0]          cur_id_d;
    logic [AW-1:0]       epc_q;
    logic [NUM_IRQ-1:0]  pending_w;
    logic [NUM_IRQ-1:0]  eligible_w;
    logic [NUM_IRQ-1:0]  sel_w;
    logic [3:0]          winner_w;

    // One synchroniser/pending cell per channel; only edge channels honour the dispatch clear.
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
        irq_sync_edge #(
            .EDGE (EDGE_MASK[g])
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .irq_async_i (irq_in[g]),
            .clr_i       (sel_w[g]),
            .pending_o   (pending_w[g])
        );
    end

    assign eligible_w = pending_w & ~mask_q;

    // Lowest-index eligible channel wins; scan downward so the last assignment is the lowest.
    always_comb begin
        winner_w = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible_w[i]) begin
                winner_w = 4'(i);
            end
        end
    end

    // One-hot of the channel being dispatched; drives both the ack and the pending clear.
    always_comb begin
        sel_w = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            sel_w[i] = (state_q == DISPATCH) && (cur_id_q == 4'(i));
        end
    end

    // Next-state logic; the winner is frozen on entry to DISPATCH so later mask changes cannot cancel it.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (global_en && (|eligible_w)) begin
                    cur_id_d = winner_w;
                    state_d  = DISPATCH;
                end
            end
            DISPATCH: state_d = SERVICE;
            SERVICE: begin
                if (eret) begin
                    state_d = RETURN;
                end
            end
            RETURN:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, serviced-channel index, EPC capture on DISPATCH exit, and mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_id_q <= 4'd0;
            epc_q    <= '0;
            mask_q   <= MASK_RST;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            if (state_q == DISPATCH) begin
                epc_q <= pc_next;
            end
            if (mask_we) begin
                mask_q <= mask_wd;
            end
        end
    end

    assign take_int   = (state_q == DISPATCH);
    assign ret_take   = (state_q == RETURN);
    assign in_service = (state_q == DISPATCH) || (state_q == SERVICE);
    assign int_ack    = sel_w;
    assign cur_id     = cur_id_q;
    assign epc_out    = epc_q;
    assign pending_q  = pending_w;
    assign vec_addr   = VEC_BASE + (AW'(cur_id_q) * STRIDE_W);

endmodule

// File: tb/tb_vectored_irq_ctrl.sv
// Directed bench for vectored_irq_ctrl with a dispatch scoreboard.
// Channel 3 is configured level-triggered, channels 0..2 edge-triggered.
// Inputs driven and outputs sampled just after the falling edge.
module tb_vectored_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        global_en;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic [31:0] pc_next;
    logic        eret;
    logic        take_int;
    logic [31:0] vec_addr;
    logic        ret_take;
    logic [31:0] epc_out;
    logic [3:0]  int_ack;
    logic        in_service;
    logic [3:0]  cur_id;
    logic [3:0]  mask_q;
    logic [3:0]  pending_q;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] vec;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vectored_irq_ctrl #(
        .NUM_IRQ   (4),
        .AW        (32),
        .VEC_BASE  (32'h0000_0180),
        .VEC_STRIDE(8),
        .EDGE_MASK (4'b0111),
        .MASK_RST  (4'b1111)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .global_en (global_en),
        .mask_we   (mask_we),
        .mask_wd   (mask_wd),
        .pc_next   (pc_next),
        .eret      (eret),
        .take_int  (take_int),
        .vec_addr  (vec_addr),
        .ret_take  (ret_take),
        .epc_out   (epc_out),
        .int_ack   (int_ack),
        .in_service(in_service),
        .cur_id    (cur_id),
        .mask_q    (mask_q),
        .pending_q (pending_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] epc);
        exp_t e;
        e.id  = 4'(id);
        e.vec = 32'h0000_0180 + 32'(id) * 32'd8;
        e.epc = epc;
        sb.push_back(e);
    endtask

    // Wait (bounded) for take_int, then check it against the oldest scoreboard entry.
    task automatic wait_dispatch(input string tag, input int budget, input int exact);
        int   c;
        exp_t e;
        c = 0;
        while (take_int !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_take_int"}, 32'(take_int), 32'd1);
        n_tests++;
        assert (sb.size() > 0)
        else begin
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (exact >= 0) chk({tag, "_latency"}, 32'(c), 32'(exact));
            chk({tag, "_cur_id"}, 32'(cur_id), 32'(e.id));
            chk({tag, "_int_ack"}, 32'(int_ack), 32'd1 << e.id);
            chk({tag, "_vec_addr"}, vec_addr, e.vec);
            chk({tag, "_in_service"}, 32'(in_service), 32'd1);
            tick();
            chk({tag, "_epc"}, epc_out, e.epc);
            chk({tag, "_take_int_1cyc"}, 32'(take_int), 32'd0);
        end
    endtask

    // Pulse eret in SERVICE; the following cycle must be RETURN with the saved EPC.
    task automatic do_eret(input string tag, input logic [31:0] epc);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk({tag, "_ret_take"}, 32'(ret_take), 32'd1);
        chk({tag, "_in_service"}, 32'(in_service), 32'd0);
        chk({tag, "_epc"}, epc_out, epc);
    endtask

    task automatic no_dispatch(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (take_int === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        irq_in    = 4'b0000;
        global_en = 1'b0;
        mask_we   = 1'b0;
        mask_wd   = 4'b0000;
        pc_next   = 32'h0;
        eret      = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_take_int", 32'(take_int), 32'd0);
        chk("rst_ret_take", 32'(ret_take), 32'd0);
        chk("rst_int_ack", 32'(int_ack), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_epc", epc_out, 32'd0);
        chk("rst_mask", 32'(mask_q), 32'hF);
        chk("rst_pending", 32'(pending_q), 32'd0);
        reset = 1'b0;
        tick();

        // Unmask everything, enable interrupts
        global_en = 1'b1;
        mask_we   = 1'b1;
        mask_wd   = 4'b0000;
        tick();
        mask_we = 1'b0;
        chk("mask_write", 32'(mask_q), 32'd0);

        // Test 1: single edge on channel 2
        pc_next = 32'h0000_1000;
        push_exp(2, 32'h0000_1000);
        irq_in = 4'b0100;
        wait_dispatch("t1", 10, 4);

        // Test 4: channel 0 pulse while channel 2 is in service
        irq_in = 4'b0101;
        tick();
        irq_in = 4'b0100;
        no_dispatch("t4_no_nest", 6);
        chk("t4_pending", 32'(pending_q), 32'h1);
        pc_next = 32'h0000_2000;
        push_exp(0, 32'h0000_2000);
        do_eret("t1_eret", 32'h0000_1000);
        wait_dispatch("t4", 10, 2);
        do_eret("t4_eret", 32'h0000_2000);
        irq_in = 4'b0000;
        no_dispatch("t4_quiet", 6);

        // Test 2: simultaneous channels 1 and 3, lowest index first
        pc_next = 32'h0000_3000;
        push_exp(1, 32'h0000_3000);
        irq_in = 4'b1010;
        wait_dispatch("t2a", 10, 4);
        chk("t2_pending_ch3", 32'(pending_q), 32'h8);
        pc_next = 32'h0000_3100;
        push_exp(3, 32'h0000_3100);
        do_eret("t2a_eret", 32'h0000_3000);
        wait_dispatch("t2b", 10, 2);
        irq_in = 4'b0000;
        repeat (5) tick();
        chk("t2_pending_clr", 32'(pending_q), 32'd0);
        do_eret("t2b_eret", 32'h0000_3100);
        no_dispatch("t2_quiet", 6);

        // Test 3: masked channel 0 pends, unmask dispatches
        mask_we = 1'b1;
        mask_wd = 4'b0001;
        tick();
        mask_we = 1'b0;
        irq_in  = 4'b0001;
        tick();
        irq_in = 4'b0000;
        no_dispatch("t3_masked", 6);
        chk("t3_pending", 32'(pending_q), 32'h1);
        pc_next = 32'h0000_4000;
        push_exp(0, 32'h0000_4000);
        mask_we = 1'b1;
        mask_wd = 4'b0000;
        tick();
        mask_we = 1'b0;
        chk("t3_mask", 32'(mask_q), 32'd0);
        wait_dispatch("t3", 10, 1);
        do_eret("t3_eret", 32'h0000_4000);

        // Test 5: level channel 3 redispatches while held
        pc_next = 32'h0000_5000;
        push_exp(3, 32'h0000_5000);
        irq_in = 4'b1000;
        wait_dispatch("t5a", 10, 4);
        push_exp(3, 32'h0000_5000);
        do_eret("t5a_eret", 32'h0000_5000);
        wait_dispatch("t5b", 10, 2);
        irq_in = 4'b0000;
        repeat (5) tick();
        do_eret("t5b_eret", 32'h0000_5000);
        no_dispatch("t5_stop", 8);
        chk("t5_pending", 32'(pending_q), 32'd0);

        // Test 6: reset during SERVICE
        pc_next = 32'h0000_6000;
        push_exp(2, 32'h0000_6000);
        irq_in = 4'b0100;
        wait_dispatch("t6", 10, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_in_service", 32'(in_service), 32'd0);
        chk("t6_take_int", 32'(take_int), 32'd0);
        chk("t6_cur_id", 32'(cur_id), 32'd0);
        chk("t6_epc", epc_out, 32'd0);
        chk("t6_mask", 32'(mask_q), 32'hF);
        chk("t6_pending", 32'(pending_q), 32'd0);
        irq_in = 4'b0000;
        tick();
        reset = 1'b0;
        eret  = 1'b1;
        tick();
        eret = 1'b0;
        chk("t6_eret_ignored", 32'(ret_take), 32'd0);
        no_dispatch("t6_quiet", 4);
        chk("t6_in_service_after", 32'(in_service), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
